// File: rtl/i2c_tx_fifo.sv
// Transmit byte FIFO between the APB register block and the I2C core.
// First-word-fall-through head, edge-qualified push, sticky error status.
module i2c_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1,
    parameter int PUSH_EDGE  = 1
) (
    input  logic                  pclk_i,
    input  logic                  preset_n_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_en_d;
    logic                  overflow;
    logic                  underflow;

    logic push_req;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic set_ovf;
    logic set_unf;

    // Status is a pure function of the registered count.
    assign count_o        = count;
    assign empty_o        = (count == '0);
    assign full_o         = (count == DEPTH_C);
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);
    assign overflow_o     = overflow;
    assign underflow_o    = underflow;
    assign rd_data_o      = empty_o ? '0 : mem[rd_ptr];

    always_comb begin
        push_req = (PUSH_EDGE != 0) ? (wr_en_i & ~wr_en_d) : wr_en_i;
        pop_req  = rd_en_i;
        do_pop   = pop_req & ~empty_o;
        do_push  = push_req & (~full_o | do_pop);
        set_ovf  = push_req & full_o & ~pop_req;
        set_unf  = pop_req & empty_o;
    end

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_en_d   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Track the level even across a flush so a held write can't re-push.
            wr_en_d <= wr_en_i;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (do_push && !do_pop)
                    count <= count + CNT_ONE;
                else if (!do_push && do_pop)
                    count <= count - CNT_ONE;
            end
            if (set_ovf)        overflow <= 1'b1;
            else if (clr_err_i) overflow <= 1'b0;
            if (set_unf)        underflow <= 1'b1;
            else if (clr_err_i) underflow <= 1'b0;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (do_push && !flush_i)
            mem[wr_ptr] <= wr_data_i;
    end

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Directed bench for i2c_tx_fifo with a queue-based reference model
// compared every falling edge, plus literal expectations per scenario.
module tb_i2c_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       afull;
    logic       aempty;
    logic       ovf;
    logic       unf;

    int checks = 0;
    int failures = 0;

    i2c_tx_fifo dut (
        .pclk_i         (clk),
        .preset_n_i     (rst_n),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .rd_en_i        (rd_en),
        .flush_i        (flush),
        .clr_err_i      (clr_err),
        .rd_data_o      (rd_data),
        .empty_o        (empty),
        .full_o         (full),
        .count_o        (count),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .overflow_o     (ovf),
        .underflow_o    (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, flags as plain bits.
    logic [7:0] q[$];
    bit m_prev_wr;
    bit m_ovf;
    bit m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_prev_wr = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            bit pushing;
            bit popping;
            bit was_full;
            bit was_empty;
            pushing   = wr_en && !m_prev_wr;
            popping   = rd_en;
            was_full  = (q.size() == 8);
            was_empty = (q.size() == 0);
            if (!flush) begin
                if (popping && !was_empty) void'(q.pop_front());
                if (pushing && (!was_full || (popping && !was_empty)))
                    q.push_back(wr_data);
            end else begin
                q.delete();
            end
            if (pushing && was_full && !popping) m_ovf = 1;
            else if (clr_err) m_ovf = 0;
            if (popping && was_empty) m_unf = 1;
            else if (clr_err) m_unf = 0;
            m_prev_wr = wr_en;
        end
    end

    always @(negedge clk) begin
        int n;
        n = q.size();
        check("m_count", 32'(count), 32'(n));
        check("m_empty", 32'(empty), 32'(n == 0));
        check("m_full", 32'(full), 32'(n == 8));
        check("m_afull", 32'(afull), 32'(n >= 6));
        check("m_aempty", 32'(aempty), 32'(n <= 1));
        check("m_ovf", 32'(ovf), 32'(m_ovf));
        check("m_unf", 32'(unf), 32'(m_unf));
        check("m_head", 32'(rd_data), (n == 0) ? 32'd0 : 32'(q[0]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(aempty), 32'd1);
        check("rst_rd", 32'(rd_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Held write level: one push only.
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        check("s1_count", 32'(count), 32'd1);
        check("s1_head", 32'(rd_data), 32'hA5);
        tick();
        tick();
        wr_en = 1'b0;
        tick();
        check("s1_count_held", 32'(count), 32'd1);
        pop();
        check("s1_empty", 32'(empty), 32'd1);

        // Fill, overflow, ordered drain across pointer wrap.
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        check("s2_full", 32'(full), 32'd1);
        check("s2_count", 32'(count), 32'd8);
        push(8'hFF);
        check("s2_ovf", 32'(ovf), 32'd1);
        check("s2_count9", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("s2_order", 32'(rd_data), 32'h10 + 32'(i));
            pop();
        end
        check("s2_empty", 32'(empty), 32'd1);
        check("s2_rd0", 32'(rd_data), 32'd0);
        clr();
        check("s2_clr", 32'(ovf), 32'd0);

        // Push and pop together while full.
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        wr_en = 1'b1;
        wr_data = 8'h55;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("s3_count", 32'(count), 32'd8);
        check("s3_ovf", 32'(ovf), 32'd0);
        check("s3_head", 32'(rd_data), 32'h21);
        for (int i = 0; i < 7; i++) pop();
        check("s3_last", 32'(rd_data), 32'h55);
        pop();
        check("s3_empty", 32'(empty), 32'd1);

        // Underflow, clear, push+pop on empty.
        pop();
        check("s4_unf", 32'(unf), 32'd1);
        check("s4_count", 32'(count), 32'd0);
        clr();
        check("s4_clr", 32'(unf), 32'd0);
        wr_en = 1'b1;
        wr_data = 8'h3C;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("s4_count1", 32'(count), 32'd1);
        check("s4_unf2", 32'(unf), 32'd1);
        check("s4_head", 32'(rd_data), 32'h3C);
        pop();
        clr();

        // Threshold flags and flush.
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        check("s5_af5", 32'(afull), 32'd0);
        push(8'h45);
        check("s5_af6", 32'(afull), 32'd1);
        for (int i = 0; i < 4; i++) pop();
        check("s5_ae2", 32'(aempty), 32'd0);
        pop();
        check("s5_ae1", 32'(aempty), 32'd1);
        check("s5_head", 32'(rd_data), 32'h45);
        wr_en = 1'b1;
        wr_data = 8'h99;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("s5_flush", 32'(count), 32'd0);
        check("s5_fempty", 32'(empty), 32'd1);
        tick();
        check("s5_norepush", 32'(count), 32'd0);
        wr_en = 1'b0;
        tick();

        // Asynchronous reset mid-stream, level held through release.
        pop();
        check("s6_unf", 32'(unf), 32'd1);
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        check("s6_count4", 32'(count), 32'd4);
        #1;
        wr_en = 1'b1;
        wr_data = 8'hD7;
        rst_n = 1'b0;
        #1;
        check("s6_rcount", 32'(count), 32'd0);
        check("s6_rempty", 32'(empty), 32'd1);
        check("s6_runf", 32'(unf), 32'd0);
        check("s6_rovf", 32'(ovf), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("s6_push", 32'(count), 32'd1);
        check("s6_head", 32'(rd_data), 32'hD7);
        tick();
        tick();
        check("s6_once", 32'(count), 32'd1);
        wr_en = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_tx_fifo.md
Name: i2c_tx_fifo

Overview:
- Transmit byte buffer between the APB register block and the I2C core.
- Accepts bytes written by the CPU through the register block's transmit register (data plus write-enable level).
- Presents them first-word-fall-through to the I2C core, which pops one byte per transmitted frame.
- Provides occupancy, threshold and sticky error status for the status register.

Parameters:
- DATA_WIDTH, 8, byte width.
- ADDR_WIDTH, 3, log2 of depth (DEPTH = 2**ADDR_WIDTH = 8).
- AF_LEVEL, 6, almost_full_o asserted when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty_o asserted when count <= AE_LEVEL.
- PUSH_EDGE, 1, 1 = push on rising edge of wr_en_i; 0 = push every cycle wr_en_i is high.

Ports:
- pclk_i  in  1  clock.
- preset_n_i  in  1  asynchronous active-low reset.
- wr_en_i  in  1  write enable from register block; may be held high for several cycles per APB write.
- wr_data_i  in  DATA_WIDTH  byte to push; valid in the push cycle.
- rd_en_i  in  1  pop strobe from I2C core; single-cycle pulse.
- flush_i  in  1  synchronous clear of contents.
- clr_err_i  in  1  clears overflow_o and underflow_o.
- rd_data_o  out  DATA_WIDTH  head byte, first-word-fall-through; 0 when empty.
- empty_o  out  1  no valid entries.
- full_o  out  1  DEPTH entries.
- count_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- almost_full_o  out  1  count >= AF_LEVEL.
- almost_empty_o  out  1  count <= AE_LEVEL.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Clock and reset: one clock, pclk_i. Reset is asynchronous and active-low on preset_n_i.
- Reset values, asserted immediately with no clock:
  - wr_ptr = 0, rd_ptr = 0, count_o = 0.
  - empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0.
  - overflow_o = 0, underflow_o = 0, rd_data_o = 0.
  - Edge-detect register (wr_en_d) = 0.
  - Storage array is not reset.
- Push qualifier:
  - PUSH_EDGE=1: push_req = wr_en_i & ~wr_en_d, where wr_en_d is wr_en_i registered each cycle. A level held N cycles produces exactly one push. Back-to-back APB writes where wr_en_i never drops produce one push; this is a documented limitation of the register-block interface.
  - PUSH_EDGE=0: push_req = wr_en_i.
- Pop qualifier: pop_req = rd_en_i.
- Effective operations:
  - do_pop = pop_req & ~empty_o.
  - do_push = push_req & (~full_o | do_pop).
- Write: on do_push, mem[wr_ptr] <= wr_data_i and wr_ptr <= wr_ptr + 1.
- Read: on do_pop, rd_ptr <= rd_ptr + 1.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- count_o: next = count + do_push - do_pop.
- Status derivation:
  - empty_o = (count == 0), full_o = (count == DEPTH).
  - almost_* flags compare count_o against the parameters.
  - All status outputs are derived from registered count, so they update the cycle after the push or pop.
- rd_data_o = mem[rd_ptr] when ~empty_o, else 0.
  - Latency push to visible head: 1 cycle (write at edge, head valid after that edge).
  - Pop: the next entry appears after the popping edge.
- Simultaneous push and pop:
  - Not empty and not full: both happen, count unchanged.
  - Full: pop frees a slot, push accepted, count stays DEPTH, no overflow.
  - Empty: push accepted, pop ignored, underflow_o set, count becomes 1.
- Error flags:
  - overflow_o set when push_req & full_o & ~pop_req; the data is dropped and the pointer is unchanged.
  - underflow_o set when pop_req & empty_o; pointers unchanged.
  - Both are sticky until clr_err_i. If a set condition and clr_err_i occur in the same cycle, set wins.
- flush_i has highest priority: wr_ptr, rd_ptr and count go to 0 the next edge. Any push or pop in that cycle is discarded. Error flags are unaffected. wr_en_d still updates, so a level held across a flush does not re-push.
- Reset mid-operation: all state returns to reset values asynchronously. The first push after reset release requires a rising edge of wr_en_i as seen after release (wr_en_d = 0, so a level already high pushes once).

Test Plan:
- Reset, then one edge-mode write of wr_data_i=8'hA5 with wr_en_i held 3 cycles -> exactly one push; count_o=1, empty_o=0, rd_data_o=8'hA5 one cycle after the first high cycle.
- Push 8 distinct bytes 8'h10..8'h17, then a 9th push of 8'hFF -> full_o=1, count_o=8, overflow_o=1; pop 8 times returns 8'h10..8'h17 in order, wrapping ptrs; then empty_o=1, rd_data_o=0.
- With FIFO full, assert push 8'h55 and pop in the same cycle -> head advances, count_o stays 8, overflow_o stays 0, 8'h55 is read as the last byte.
- Empty FIFO, pop pulse -> underflow_o=1, count_o=0; clr_err_i pulse -> underflow_o=0; simultaneous push 8'h3C with pop when empty -> count_o=1, underflow_o=1, head=8'h3C.
- Fill to 6 entries -> almost_full_o=1 when count_o=6, not at 5; drain to 1 -> almost_empty_o=1; flush_i with a push in the same cycle -> count_o=0, empty_o=1, push discarded.
- Assert preset_n_i low asynchronously mid-stream with count_o=4 -> count_o=0, empty_o=1, flags 0 with no clock edge; wr_en_i held high through release -> one push after release.
